// File: rtl/wimax_pkg.sv
// -----------------------------------------------------------------------------
// wimax_pkg
//   Shared constants and types for the WiMAX-style coding chain.
//   - NIN   : uncoded bits per block (Ncbps/2 for QPSK)
//   - NCBPS : coded bits per block
//   - CNT_W : width of the in-block bit index counters
//   - G1/G2 : K=7 generator polynomials in octal, MSB taps the current input
//   - enc_state_t : read-side FSM states of the convolutional encoder
//   - gen_bit()   : one generator output from the current input and state
// -----------------------------------------------------------------------------
package wimax_pkg;

    localparam int unsigned NIN   = 96;
    localparam int unsigned NCBPS = 192;
    localparam int unsigned CNT_W = $clog2(NIN);

    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o133;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ENC_X = 2'd2,
        ST_ENC_Y = 2'd3
    } enc_state_t;

    // s[0] is D1 (most recent past input), s[5] is D6. The tap vector is
    // ordered MSB-first as {u, D1..D6} so that bit 6 of the octal generator
    // multiplies the current input.
    function automatic logic gen_bit(input logic [6:0] g,
                                     input logic       u,
                                     input logic [5:0] s);
        logic [6:0] taps;
        taps = {u, s[0], s[1], s[2], s[3], s[4], s[5]};
        return ^(g & taps);
    endfunction

endpackage

// File: rtl/cc_tailbite_core.sv
// -----------------------------------------------------------------------------
// cc_tailbite_core
//   Six-bit shift-register core of the K=7 rate-1/2 convolutional encoder.
//   Holds D1..D6 and produces either the X (G1) or Y (G2) output bit for the
//   current input. The state is preloaded for tail-biting before each block.
//
// Ports
//   clk       in   clock
//   load_i    in   load preload_i into the state (takes priority over shift)
//   preload_i in   6-bit initial state, bit 0 = D1 ... bit 5 = D6
//   u_i       in   current uncoded bit
//   shift_i   in   shift u_i into the state after the Y bit is consumed
//   sel_y_i   in   0: output X bit, 1: output Y bit
//   bit_o     out  coded bit for the current input and state
// -----------------------------------------------------------------------------
module cc_tailbite_core
    import wimax_pkg::*;
(
    input  logic       clk,
    input  logic       load_i,
    input  logic [5:0] preload_i,
    input  logic       u_i,
    input  logic       shift_i,
    input  logic       sel_y_i,
    output logic       bit_o
);

    logic [5:0] s_q;
    logic [5:0] s_d;

    always_comb begin
        s_d = s_q;
        if (load_i) begin
            s_d = preload_i;
        end else if (shift_i) begin
            s_d = {s_q[4:0], u_i};
        end
    end

    // Pure datapath state: every block starts with a load, so no reset needed.
    always_ff @(posedge clk) begin
        s_q <= s_d;
    end

    assign bit_o = sel_y_i ? gen_bit(G2, u_i, s_q) : gen_bit(G1, u_i, s_q);

endmodule

// File: rtl/fec_encoder_cc.sv
// -----------------------------------------------------------------------------
// fec_encoder_cc
//   Rate-1/2 tail-biting convolutional encoder (K=7, G1=171, G2=133 octal)
//   feeding the QPSK interleaver. Uncoded bits arrive serially and are
//   collected into a two-bank ping-pong store of NIN bits per bank. Each full
//   bank is encoded into 2*NIN coded bits emitted serially as X0 Y0 X1 Y1 ...
//   The encoder state is preloaded with the last six bits of the block so the
//   trellis starts and ends in the same state and no tail bits are needed.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   resetN     in   asynchronous active-low reset
//   data_in    in   uncoded bit; first accepted bit of a block is u[0]
//   valid_in   in   data_in valid; transfer on valid_in && ready_out
//   ready_out  out  a write bank is free
//   data_out   out  coded bit
//   valid_out  out  data_out valid; transfer on valid_out && ready_in
//   ready_in   in   downstream can accept
//   last_out   out  high with the final coded bit Y[NIN-1] of a block
// -----------------------------------------------------------------------------
module fec_encoder_cc
    import wimax_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic data_in,
    input  logic valid_in,
    output logic ready_out,
    output logic data_out,
    output logic valid_out,
    input  logic ready_in,
    output logic last_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Ping-pong storage (datapath, not reset)
    logic [NIN-1:0]   bank_q [2];

    // Control state
    logic [1:0]       full_q, full_d;
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    enc_state_t       state_q, state_d;

    logic             wr_fire;
    logic             wr_last;
    logic             rd_done;

    logic [NIN-1:0]   rd_bank;
    logic [5:0]       preload;
    logic             u_bit;
    logic             core_load;
    logic             core_shift;
    logic             core_sel_y;
    logic             core_bit;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign ready_out = !full_q[wsel_q];
    assign wr_fire   = valid_in && ready_out;
    assign wr_last   = wr_fire && (wcnt_q == CNT_LAST);

    always_comb begin
        wsel_d = wsel_q;
        wcnt_d = wcnt_q;
        if (wr_fire) begin
            if (wr_last) begin
                wcnt_d = '0;
                wsel_d = !wsel_q;
            end else begin
                wcnt_d = wcnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_q[wsel_q][wcnt_q] <= data_in;
        end
    end

    // Filling one bank and releasing the other touch different flag bits.
    // They cannot target the same bank: a bank being read is full, so it is
    // never the write bank while ready_out is high.
    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wsel_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rsel_q] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign rd_bank = bank_q[rsel_q];
    assign u_bit   = rd_bank[rcnt_q];

    // Tail-biting preload: D1 = u[NIN-1], D2 = u[NIN-2], ... D6 = u[NIN-6]
    assign preload = {rd_bank[NIN-6], rd_bank[NIN-5], rd_bank[NIN-4],
                      rd_bank[NIN-3], rd_bank[NIN-2], rd_bank[NIN-1]};

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        rsel_d     = rsel_q;
        rd_done    = 1'b0;
        core_load  = 1'b0;
        core_shift = 1'b0;
        core_sel_y = 1'b0;
        valid_out  = 1'b0;
        last_out   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (full_q[rsel_q]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                rcnt_d    = '0;
                state_d   = ST_ENC_X;
            end
            ST_ENC_X: begin
                valid_out = 1'b1;
                if (ready_in) begin
                    state_d = ST_ENC_Y;
                end
            end
            ST_ENC_Y: begin
                valid_out  = 1'b1;
                core_sel_y = 1'b1;
                last_out   = (rcnt_q == CNT_LAST);
                if (ready_in) begin
                    core_shift = 1'b1;
                    if (rcnt_q != CNT_LAST) begin
                        rcnt_d  = rcnt_q + CNT_ONE;
                        state_d = ST_ENC_X;
                    end else begin
                        rd_done = 1'b1;
                        rsel_d  = !rsel_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gated by valid_out so the bit reads 0 whenever nothing is offered,
    // including directly out of reset before any bank has been written.
    assign data_out = valid_out && core_bit;

    cc_tailbite_core u_core (
        .clk       (clk),
        .load_i    (core_load),
        .preload_i (preload),
        .u_i       (u_bit),
        .shift_i   (core_shift),
        .sel_y_i   (core_sel_y),
        .bit_o     (core_bit)
    );

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            full_q  <= '0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_fec_encoder_cc.sv
// -----------------------------------------------------------------------------
// tb_fec_encoder_cc
//   Bench for the tail-biting convolutional encoder. Expected coded streams
//   come from a circular convolution of each block with the two generator
//   polynomials; directed patterns also carry hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_fec_encoder_cc;

    localparam int N  = 96;
    localparam int NC = 2 * N;
    localparam logic [6:0] GX = 7'o171;
    localparam logic [6:0] GY = 7'o133;

    logic clk      = 1'b0;
    logic resetN   = 1'b0;
    logic data_in  = 1'b0;
    logic valid_in = 1'b0;
    logic ready_in = 1'b1;
    logic ready_out;
    logic data_out;
    logic valid_out;
    logic last_out;

    always #5 clk = ~clk;

    fec_encoder_cc dut (
        .clk       (clk),
        .resetN    (resetN),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .last_out  (last_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]  tx_blk [3];
    int            tx_n;
    logic [NC-1:0] rx_bits [3];
    int            last_acc_cyc;
    int            first_vld_cyc;
    int            last_bad;
    int            stall_bad;
    int            stall_seen;
    bit            stall_test       = 1'b0;
    bit            rdy_drop_checked = 1'b0;
    bit            rx_done          = 1'b0;

    typedef struct {
        logic [N-1:0] blk;
        logic [5:0]   x_head;
        logic [5:0]   y_head;
        logic         x_last;
        logic         y_last;
        int           ones;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [NC-1:0] got, input logic [NC-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Circular convolution: coded bit X[i] is the parity of u[(i-j) mod N]
    // over the taps j where generator bit (6-j) is set; same for Y.
    function automatic logic [NC-1:0] encode(input logic [N-1:0] u);
        logic [NC-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            logic x;
            logic y;
            x = 1'b0;
            y = 1'b0;
            for (int j = 0; j < 7; j++) begin
                int idx;
                idx = (i - j + N) % N;
                if (GX[6-j]) x ^= u[idx];
                if (GY[6-j]) y ^= u[idx];
            end
            c[2*i]   = x;
            c[2*i+1] = y;
        end
        return c;
    endfunction

    task automatic drive_tx();
        int i;
        int guard;
        i = 0;
        guard = 0;
        @(posedge clk); #1;
        while (i < tx_n * N && guard < 5000) begin
            valid_in = 1'b1;
            data_in  = tx_blk[i / N][i % N];
            @(negedge clk);
            if (stall_test && i == NC && !rdy_drop_checked) begin
                rdy_drop_checked = 1'b1;
                check("ready_out_low_both_full", NC'(ready_out), NC'(0));
            end
            if (ready_out) begin
                i++;
                if (i == tx_n * N) last_acc_cyc = cyc + 1;
            end
            @(posedge clk); #1;
            guard++;
        end
        valid_in = 1'b0;
        data_in  = 1'b0;
        if (i < tx_n * N) check("tx_timeout_accepted", NC'(i), NC'(tx_n * N));
    endtask

    task automatic collect(input int nblk);
        int   idx;
        int   guard;
        logic prev_stall;
        logic prev_d;
        logic prev_l;
        idx = 0;
        guard = 0;
        prev_stall = 1'b0;
        prev_d = 1'b0;
        prev_l = 1'b0;
        first_vld_cyc = -1;
        last_bad   = 0;
        stall_bad  = 0;
        stall_seen = 0;
        while (idx < nblk * NC && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (prev_stall) begin
                stall_seen++;
                if (!valid_out || data_out !== prev_d || last_out !== prev_l) stall_bad++;
            end
            if (valid_out && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (valid_out && ready_in) begin
                rx_bits[idx / NC][idx % NC] = data_out;
                if (last_out !== ((idx % NC) == NC - 1)) last_bad++;
                idx++;
            end
            prev_stall = valid_out && !ready_in;
            prev_d     = data_out;
            prev_l     = last_out;
        end
        if (idx < nblk * NC) check("rx_timeout_received", NC'(idx), NC'(nblk * NC));
        rx_done = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] got;
        logic [5:0]    xh;
        logic [5:0]    yh;
        int            vcount;

        // Directed patterns with hand-derived expectations
        vecs[0].blk = '0;  vecs[0].x_head = 6'b000000; vecs[0].y_head = 6'b000000;
        vecs[0].x_last = 1'b0; vecs[0].y_last = 1'b0; vecs[0].ones = 0;
        vecs[1].blk = '1;  vecs[1].x_head = 6'b111111; vecs[1].y_head = 6'b111111;
        vecs[1].x_last = 1'b1; vecs[1].y_last = 1'b1; vecs[1].ones = NC;
        vecs[2].blk = '0;  vecs[2].blk[0] = 1'b1;
        vecs[2].x_head = 6'b001111; vecs[2].y_head = 6'b101101;
        vecs[2].x_last = 1'b0; vecs[2].y_last = 1'b0; vecs[2].ones = 10;
        vecs[3].blk = '0;  vecs[3].blk[N-1] = 1'b1;
        vecs[3].x_head = 6'b100111; vecs[3].y_head = 6'b110110;
        vecs[3].x_last = 1'b1; vecs[3].y_last = 1'b1; vecs[3].ones = 10;

        // Reset state
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready_out", NC'(ready_out), NC'(1));
        check("reset_valid_out", NC'(valid_out), NC'(0));
        check("reset_data_out",  NC'(data_out),  NC'(0));
        check("reset_last_out",  NC'(last_out),  NC'(0));
        @(posedge clk); #1;
        resetN = 1'b1;

        // Directed blocks, no backpressure
        for (int v = 0; v < 4; v++) begin
            tx_blk[0] = vecs[v].blk;
            tx_n      = 1;
            ready_in  = 1'b1;
            fork
                drive_tx();
                collect(1);
            join
            got = rx_bits[0];
            for (int k = 0; k < 6; k++) begin
                xh[k] = got[2*k];
                yh[k] = got[2*k+1];
            end
            check($sformatf("vec%0d_x_head", v), NC'(xh), NC'(vecs[v].x_head));
            check($sformatf("vec%0d_y_head", v), NC'(yh), NC'(vecs[v].y_head));
            check($sformatf("vec%0d_x_last", v), NC'(got[NC-2]), NC'(vecs[v].x_last));
            check($sformatf("vec%0d_y_last", v), NC'(got[NC-1]), NC'(vecs[v].y_last));
            check($sformatf("vec%0d_ones", v), NC'($countones(got)), NC'(vecs[v].ones));
            check($sformatf("vec%0d_model", v), got, encode(vecs[v].blk));
            check($sformatf("vec%0d_last_out_pos", v), NC'(last_bad), NC'(0));
            check($sformatf("vec%0d_latency", v), NC'(first_vld_cyc - last_acc_cyc), NC'(2));
            repeat (3) @(posedge clk);
        end

        // Three random blocks back to back with an initial downstream stall
        for (int b = 0; b < 3; b++) tx_blk[b] = {$urandom, $urandom, $urandom};
        tx_n             = 3;
        stall_test       = 1'b1;
        rdy_drop_checked = 1'b0;
        rx_done          = 1'b0;
        ready_in         = 1'b0;
        fork
            drive_tx();
            collect(3);
            begin
                repeat (250) @(posedge clk);
                while (!rx_done) begin
                    #1;
                    ready_in = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                end
            end
        join
        ready_in   = 1'b1;
        stall_test = 1'b0;
        check("rand_ready_drop_reached", NC'(rdy_drop_checked), NC'(1));
        check("rand_stall_observed", NC'(stall_seen > 100), NC'(1));
        check("rand_stall_stable", NC'(stall_bad), NC'(0));
        check("rand_last_out_pos", NC'(last_bad), NC'(0));
        for (int b = 0; b < 3; b++) begin
            check($sformatf("rand_blk%0d_model", b), rx_bits[b], encode(tx_blk[b]));
        end
        repeat (3) @(posedge clk);

        // Reset while block 1 is being encoded and block 2 is full
        tx_blk[0] = {$urandom, $urandom, $urandom};
        tx_blk[1] = {$urandom, $urandom, $urandom};
        tx_n      = 2;
        drive_tx();
        repeat (2) @(posedge clk);
        #3;
        check("pre_reset_valid_out", NC'(valid_out), NC'(1));
        check("pre_reset_ready_out", NC'(ready_out), NC'(0));
        resetN = 1'b0;
        #1;
        check("midrst_ready_out", NC'(ready_out), NC'(1));
        check("midrst_valid_out", NC'(valid_out), NC'(0));
        check("midrst_data_out",  NC'(data_out),  NC'(0));
        check("midrst_last_out",  NC'(last_out),  NC'(0));
        @(posedge clk);
        @(posedge clk); #1;
        resetN = 1'b1;
        vcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_out) vcount++;
        end
        check("post_reset_no_output", NC'(vcount), NC'(0));

        tx_blk[0] = {$urandom, $urandom, $urandom};
        tx_n      = 1;
        fork
            drive_tx();
            collect(1);
        join
        check("post_reset_model", rx_bits[0], encode(tx_blk[0]));
        check("post_reset_last_out_pos", NC'(last_bad), NC'(0));
        check("post_reset_latency", NC'(first_vld_cyc - last_acc_cyc), NC'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fec_encoder_cc.md
# fec_encoder_cc

- Rate-1/2 tail-biting convolutional encoder (K=7) sitting directly upstream of the QPSK interleaver.
- Accepts a serial stream of uncoded bits in blocks of Nin, buffers each block in a two-bank ping-pong store, and emits 2·Nin coded bits serially as X0 Y0 X1 Y1 …
- The coded stream drives the interleaver's data_in/valid_in; the interleaver's backpressure arrives on ready_in.

## Interface
- Nin, 96: uncoded bits per block (Ncbps/2 for QPSK, Ncbps=192).
- G1, 7'o171: X generator polynomial.
- G2, 7'o133: Y generator polynomial.
- clk  in  1  clock; all state updates on posedge.
- resetN  in  1  reset, asynchronous, active-low.
- data_in  in  1  uncoded bit; first accepted bit of a block is u[0].
- valid_in  in  1  data_in valid; transfer on valid_in && ready_out.
- ready_out  out  1  a write bank is free.
- data_out  out  1  coded bit.
- valid_out  out  1  data_out valid; transfer on valid_out && ready_in.
- ready_in  in  1  downstream (interleaver) can accept.
- last_out  out  1  high with the final coded bit (Y[Nin-1]) of a block.

## Operation
- Storage: two banks of Nin bits, each with a full flag, a write-bank pointer wsel and a read-bank pointer rsel.
  - ready_out = !full[wsel].
  - Each input transfer writes bank[wsel][wcnt]; wcnt counts 0..Nin-1.
  - On the transfer at wcnt=Nin-1: set full[wsel], toggle wsel, clear wcnt.
- Read FSM states: IDLE, LOAD, ENC_X, ENC_Y.
  - IDLE -> LOAD when full[rsel].
  - LOAD (one cycle): preload the tail-biting state s[k] = bank[rsel][Nin-1-k] for k=0..5, with s[0]=D1 … s[5]=D6. Clear rcnt.
  - ENC_X: valid_out=1, data_out = u ^ s0 ^ s1 ^ s2 ^ s5, where u = bank[rsel][rcnt]. Hold until transfer, then go to ENC_Y.
  - ENC_Y: valid_out=1, data_out = u ^ s1 ^ s2 ^ s4 ^ s5. On transfer, shift s <= {s[4:0], u}.
    - If rcnt<Nin-1: increment rcnt and go to ENC_X.
    - Otherwise: last_out=1, clear full[rsel], toggle rsel, go to IDLE.
- Tail-biting guarantees the final encoder state equals the preloaded state; no tail bits are emitted.
- Index counters are $clog2(Nin) bits; all XORs are 1-bit.
- Simultaneous fill of one bank and release of the other on the same edge are independent; both take effect.
- Filling while the read side is stalled is allowed until both banks are full; ready_out then drops.

## Timing
- Reset values: ready_out=1, valid_out=0, data_out=0, last_out=0. FSM=IDLE, wsel=rsel=0, full=00, counters=0.
- Reset mid-block discards partial and full banks; no output is produced for them.
- Latency: valid_out rises 2 cycles after the edge accepting u[Nin-1] (one cycle to set full, one in LOAD).
- Output throughput with ready_in=1 is 1 coded bit/cycle, i.e. one input block per 2·Nin+2 cycles.
  - The input stalls for roughly Nin cycles per block at sustained input rate.
- data_out, valid_out and last_out are functions of registered state only. They hold stable while valid_out && !ready_in.
- ready_out deasserts the cycle after the bank-full edge if full[wsel] is then set.

## Structure
- Shared package wimax_pkg holds: NIN=96, NCBPS=192, G1/G2 octal constants, and the read-FSM state enum.
- One sub-module, cc_tailbite_core:
  - Inputs: load, preload vector, u, shift enable, sel_y.
  - Holds the 6-bit state and produces the X/Y bit.
- Ping-pong banks, flags, counters and FSM stay in fec_encoder_cc.

## Test plan
- All-zero block, ready_in=1 -> 192 zeros. last_out only on the 192nd bit. valid_out first high 2 cycles after the last input.
- All-ones block -> 192 ones (state 111111; each generator XORs five ones).
- Impulse u[0]=1, rest 0 -> coded stream 11 10 11 11 00 01 11 followed by 178 zeros.
- Tail-biting wrap, u[95]=1, rest 0 -> X0..5 = 1,1,1,0,0,1 and Y0..5 = 0,1,1,0,1,1; zeros for bits 6..94; X95=Y95=1.
- Three back-to-back random blocks, ready_in held low for the first 250 cycles:
  - ready_out drops after 192 accepted bits.
  - Output must hold stable under stall.
  - Output then matches the golden model block-by-block, in order.
- resetN pulsed mid-way through the encoding of block 1 while block 2 is full -> all outputs go to reset values at once. The next fresh block encodes correctly from u[0].
